// File: rtl/led_wave_sequencer.sv
// LED wave sequencer: prescaled step ticks, applied on PWM period boundaries, wrap or bounce sweep.
// Optional gamma-corrected duty levels when LED_WAVE_GAMMA_EN is defined.
module led_wave_sequencer #(
    parameter int unsigned DIV_W    = 28,
    parameter int unsigned BASE_BIT = 20,
    parameter int unsigned LAST_IDX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sw,
    input  logic       bounce,
    input  logic       sync_in,
    output logic [3:0] led_index,
    output logic [3:0] prev_index,
    output logic [3:0] dutyc,
    output logic       dir,
    output logic       step_pulse,
    output logic       overrun
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned SEL_W = $clog2(DIV_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [2:0]         sw_meta_q, sw_s_q;
    logic               tap_q, tap_d;
    logic               tick_q, tick_d;
    logic               pending_q, pending_d;
    logic [IDX_W-1:0]   led_index_d, prev_index_d, dutyc_d;
    logic               dir_d, step_pulse_d, overrun_d;

    logic [SEL_W-1:0]   tap_sel_c;
    logic               tap_bit_c;
    logic               run_c, apply_c;
    logic [IDX_W-1:0]   nxt_idx_c;
    logic               nxt_dir_c;

    function automatic logic [IDX_W-1:0] duty_of(input logic [IDX_W-1:0] i);
`ifdef LED_WAVE_GAMMA_EN
        logic [IDX_W-1:0] g;
        case (i)
            4'd0, 4'd1, 4'd2:  g = 4'd0;
            4'd3, 4'd4, 4'd5:  g = 4'd1;
            4'd6, 4'd7:        g = 4'd2;
            4'd8:              g = 4'd3;
            4'd9:              g = 4'd4;
            4'd10:             g = 4'd5;
            4'd11:             g = 4'd6;
            4'd12:             g = 4'd8;
            4'd13:             g = 4'd10;
            4'd14:             g = 4'd12;
            default:           g = 4'd15;
        endcase
        return g;
`else
        return i;
`endif
    endfunction

    // Speed tap and sweep direction decode
    always_comb begin
        tap_sel_c = SEL_W'(BASE_BIT) + SEL_W'(sw_s_q);
        tap_bit_c = presc_q[tap_sel_c];
        run_c     = (state_q == RUN) && enable;
        apply_c   = run_c && pending_q && sync_in;

        nxt_idx_c = led_index + IDX_W'(1);
        nxt_dir_c = 1'b1;
        if (!bounce) begin
            if (led_index >= LAST) nxt_idx_c = '0;
        end else if (dir) begin
            if (led_index >= LAST) begin
                nxt_idx_c = LAST - IDX_W'(1);
                nxt_dir_c = 1'b0;
            end
        end else if (led_index == '0) begin
            nxt_idx_c = IDX_W'(1);
        end else begin
            nxt_idx_c = led_index - IDX_W'(1);
            nxt_dir_c = 1'b0;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        presc_d      = enable ? presc_q + DIV_W'(1) : '0;
        tap_d        = tap_bit_c;
        tick_d       = tap_bit_c & ~tap_q;
        pending_d    = pending_q;
        led_index_d  = led_index;
        prev_index_d = prev_index;
        dutyc_d      = dutyc;
        dir_d        = dir;
        step_pulse_d = apply_c;
        overrun_d    = overrun | (run_c & tick_q & pending_q & ~apply_c);

        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A tick landing on the apply edge stays queued for the next sync
        if (!run_c)         pending_d = 1'b0;
        else if (apply_c)   pending_d = tick_q;
        else if (tick_q)    pending_d = 1'b1;

        if (apply_c) begin
            prev_index_d = led_index;
            led_index_d  = nxt_idx_c;
            dir_d        = nxt_dir_c;
            dutyc_d      = duty_of(nxt_idx_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            tap_q      <= 1'b0;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
            led_index  <= '0;
            prev_index <= '0;
            dutyc      <= '0;
            dir        <= 1'b1;
            step_pulse <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            tap_q      <= tap_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            led_index  <= led_index_d;
            prev_index <= prev_index_d;
            dutyc      <= dutyc_d;
            dir        <= dir_d;
            step_pulse <= step_pulse_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_led_wave_sequencer.sv
// Scoreboard bench for led_wave_sequencer: driver queues expected steps, monitor checks each step_pulse.
`timescale 1ns/1ps
module tb_led_wave_sequencer;

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned BASE_BIT = 2;
    localparam int unsigned LAST_IDX = 15;

    logic       clk = 1'b0;
    logic       rst, enable, bounce, sync_in;
    logic [2:0] sw;
    logic [3:0] led_index, prev_index, dutyc;
    logic       dir, step_pulse, overrun;

    led_wave_sequencer #(.DIV_W(DIV_W), .BASE_BIT(BASE_BIT), .LAST_IDX(LAST_IDX)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sw(sw), .bounce(bounce), .sync_in(sync_in),
        .led_index(led_index), .prev_index(prev_index), .dutyc(dutyc), .dir(dir),
        .step_pulse(step_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] prev;
        logic [3:0] duty;
        logic       dir;
        int         gap;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_step = 0;
    logic [3:0] m_idx = 4'd0;
    int         lat;

`ifdef LED_WAVE_GAMMA_EN
    localparam logic [3:0] GAMMA [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                                          4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};
    function automatic logic [3:0] f_exp(input logic [3:0] i);
        return GAMMA[i];
    endfunction
`else
    function automatic logic [3:0] f_exp(input logic [3:0] i);
        return i;
    endfunction
`endif

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int nxt, input logic d, input int gap);
        exp_t e;
        e.idx  = 4'(nxt);
        e.prev = m_idx;
        e.duty = f_exp(4'(nxt));
        e.dir  = d;
        e.gap  = gap;
        q.push_back(e);
        m_idx = 4'(nxt);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, output int n);
        int budget;
        budget = q.size() * 40 + 50;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            wait_cyc(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout got_pending=%0d exp_pending=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"},     int'(led_index),  0);
        check({tag, "_prev"},    int'(prev_index), 0);
        check({tag, "_duty"},    int'(dutyc),      0);
        check({tag, "_dir"},     int'(dir),        1);
        check({tag, "_pulse"},   int'(step_pulse), 0);
        check({tag, "_overrun"}, int'(overrun),    0);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every step_pulse must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && step_pulse) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step got_idx=%0d exp=no_step", led_index);
                end else begin
                    mon_e = q.pop_front();
                    check("step_idx",  int'(led_index),  int'(mon_e.idx));
                    check("step_prev", int'(prev_index), int'(mon_e.prev));
                    check("step_duty", int'(dutyc),      int'(mon_e.duty));
                    check("step_dir",  int'(dir),        int'(mon_e.dir));
                    if (mon_e.gap != 0) check("step_gap", cyc - last_step, mon_e.gap);
                end
                last_step = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; sw = 3'd0; bounce = 1'b0; sync_in = 1'b1;
        wait_cyc(2);
        check_reset_outputs("reset");

        // Wrap sweep up to index 7, then asynchronous reset mid-run
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 7; i++) push(i, 1'b1, (i == 1) ? 0 : 8);
        drain("wrap_to_7", lat);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        m_idx = 4'd0;
        wait_cyc(2);
        rst = 1'b0;

        // Full wrap sweep from 0
        for (int i = 1; i <= 15; i++) push(i, 1'b1, (i == 1) ? 0 : 8);
        push(0, 1'b1, 8);
        push(1, 1'b1, 8);
        drain("wrap_full", lat);

        // Bounce sweep, then switch back to wrap while descending
        bounce = 1'b1;
        for (int i = 2; i <= 15; i++) push(i, 1'b1, 8);
        for (int i = 14; i >= 0; i--) push(i, 1'b0, 8);
        for (int i = 1; i <= 15; i++) push(i, 1'b1, 8);
        push(14, 1'b0, 8);
        push(13, 1'b0, 8);
        drain("bounce", lat);
        bounce = 1'b0;
        push(14, 1'b1, 8);
        push(15, 1'b1, 8);
        push(0, 1'b1, 8);
        drain("bounce_to_wrap", lat);

        // Sparse sync: ticks coalesce, overrun goes sticky, one step per sync pulse
        sync_in = 1'b0;
        check("overrun_before", int'(overrun), 0);
        wait_cyc(20);
        check("overrun_after_2_ticks", int'(overrun), 1);
        for (int i = 1; i <= 4; i++) push(i, 1'b1, (i == 1) ? 0 : 32);
        for (int k = 0; k < 4; k++) begin
            sync_in = 1'b1;
            wait_cyc(1);
            sync_in = 1'b0;
            wait_cyc(31);
        end
        drain("sparse_sync", lat);

        // Hold at index 5 with enable low
        sync_in = 1'b1;
        push(5, 1'b1, 0);
        drain("to_5", lat);
        enable = 1'b0;
        wait_cyc(100);
        check("hold_idx",  int'(led_index),  5);
        check("hold_prev", int'(prev_index), 4);
        check("hold_duty", int'(dutyc),      int'(f_exp(4'd5)));
        push(6, 1'b1, 0);
        enable = 1'b1;
        drain("reenable", lat);
        // Prescaler restarts at 0: tap bit 2 rises at count 4, then tick and pending stages
        check("reenable_latency", lat, 7);
        push(7, 1'b1, 8);
        drain("after_reenable", lat);
        check("overrun_sticky", int'(overrun), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
